// File: rtl/wave_capture.sv
// Triggered waveform capture: waits for a rising zero crossing, stores N_SAMPLES
// samples with min/max/crossing statistics, then streams them out over a valid/ready port.
module wave_capture #(
    parameter int N_SAMPLES = 100,
    parameter int WIDTH     = 8
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic signed [WIDTH-1:0]            wave_in,
    input  logic                               in_valid,
    input  logic                               arm,
    input  logic                               abort,
    input  logic                               rd_ready,
    output logic signed [WIDTH-1:0]            rd_data,
    output logic                               rd_valid,
    output logic                               rd_last,
    output logic                               busy,
    output logic                               done,
    output logic signed [WIDTH-1:0]            min_val,
    output logic signed [WIDTH-1:0]            max_val,
    output logic [$clog2(N_SAMPLES+1)-1:0]     zc_count
);

    localparam int IDX_W = $clog2(N_SAMPLES);
    localparam int ZC_W  = $clog2(N_SAMPLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE, READOUT} state_t;

    state_t                  state, state_next;
    logic signed [WIDTH-1:0] prev_sample;
    logic signed [WIDTH-1:0] mem [N_SAMPLES];
    logic [IDX_W-1:0]        wr_idx;
    logic [IDX_W-1:0]        rd_idx;
    logic                    crossing;
    logic                    trigger;
    logic                    cap_wr;
    logic                    handshake;

    // Sign-bit test: previous sample negative, current sample non-negative.
    assign crossing  = in_valid && prev_sample[WIDTH-1] && !wave_in[WIDTH-1];
    assign trigger   = (state == WAIT_TRIG) && crossing && !abort;
    assign cap_wr    = (state == CAPTURE) && in_valid && !abort;
    assign handshake = rd_valid && rd_ready;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:      if (arm) state_next = WAIT_TRIG;
            WAIT_TRIG: if (crossing) state_next = CAPTURE;
            CAPTURE:   if (in_valid && wr_idx == LAST_IDX) state_next = READOUT;
            READOUT:   if (handshake && rd_last) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
        if (abort) state_next = IDLE;
    end

    always_comb begin
        busy     = (state != IDLE);
        rd_valid = (state == READOUT);
        rd_last  = rd_valid && (rd_idx == LAST_IDX);
        rd_data  = rd_valid ? mem[rd_idx] : '0;
    end

    // Sample storage is deliberately not reset.
    always_ff @(posedge clock) begin
        if (trigger)     mem[0]      <= wave_in;
        else if (cap_wr) mem[wr_idx] <= wave_in;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prev_sample <= '0;
            wr_idx      <= '0;
            rd_idx      <= '0;
            min_val     <= '0;
            max_val     <= '0;
            zc_count    <= '0;
            done        <= 1'b0;
        end else begin
            if (in_valid) prev_sample <= wave_in;
            done <= !abort && handshake && rd_last;

            if (trigger) begin
                wr_idx   <= IDX_W'(1);
                min_val  <= wave_in;
                max_val  <= wave_in;
                zc_count <= '0;
            end else if (cap_wr) begin
                wr_idx <= (wr_idx == LAST_IDX) ? '0 : wr_idx + IDX_W'(1);
                if (wave_in < min_val) min_val <= wave_in;
                if (wave_in > max_val) max_val <= wave_in;
                if (crossing) zc_count <= zc_count + ZC_W'(1);
            end

            if (handshake && !abort) rd_idx <= rd_last ? '0 : rd_idx + IDX_W'(1);

            if (abort) begin
                wr_idx <= '0;
                rd_idx <= '0;
            end
        end
    end

endmodule

// File: doc/wave_capture.md
WAVE_CAPTURE -- requirements
Module: wave_capture

Interface
REQ-001 Parameter N_SAMPLES, default 100, is the number of samples captured per acquisition; legal range is 2 or more.
REQ-002 Parameter WIDTH, default 8, is the sample width in two's complement.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset; sampled on the rising edge of clock.
REQ-005 wave_in  input  WIDTH  signed sample from the waveform generator or filter path.
REQ-006 in_valid  input  1  wave_in is a valid sample this cycle.
REQ-007 arm  input  1  single-cycle request to start an acquisition.
REQ-008 abort  input  1  forces return to IDLE.
REQ-009 rd_ready  input  1  downstream accepts rd_data this cycle.
REQ-010 rd_data  output  WIDTH  signed captured sample being read out.
REQ-011 rd_valid  output  1  rd_data is valid.
REQ-012 rd_last  output  1  rd_data is sample N_SAMPLES-1.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 done  output  1  one-cycle pulse when the readout completes.
REQ-015 min_val, max_val  output  WIDTH each  signed minimum and maximum of the captured samples.
REQ-016 zc_count  output  $clog2(N_SAMPLES+1)  count of rising zero crossings inside the capture window.

Function
REQ-017 FSM states: IDLE, WAIT_TRIG, CAPTURE, READOUT.
REQ-018 IDLE -> WAIT_TRIG on arm=1; arm is ignored in every other state.
REQ-019 prev_sample register: loads wave_in on every in_valid=1 cycle in all states; reset value 0.
REQ-020 Trigger condition: in_valid=1, prev_sample<0, wave_in>=0 (rising zero crossing).
REQ-021 WAIT_TRIG -> CAPTURE when the trigger condition holds; that trigger sample is written as sample 0.
REQ-022 CAPTURE writes each in_valid=1 sample to the next index; in_valid=0 cycles write nothing and do not advance the index.
REQ-023 CAPTURE -> READOUT on the cycle sample N_SAMPLES-1 is written; no further samples are stored.
REQ-024 min_val and max_val: both load sample 0 at the trigger; each subsequent capture write updates them with signed compare.
REQ-025 zc_count: cleared at the trigger; increments for each capture write at index 1 to N_SAMPLES-1 that meets the rising-crossing condition against prev_sample.
REQ-026 min_val, max_val and zc_count hold their values from the end of CAPTURE until the next trigger.
REQ-027 READOUT: rd_valid=1 from the first READOUT cycle, with rd_data=sample 0.
REQ-028 Readout handshake occurs when rd_valid=1 and rd_ready=1; the index advances by one per handshake.
REQ-029 rd_data must stay stable while rd_valid=1 and rd_ready=0.
REQ-030 rd_last=1 only while rd_valid=1 and the index is N_SAMPLES-1.
REQ-031 On the handshake with rd_last=1: next state is IDLE, done=1 for exactly that next cycle, and rd_valid=0.
REQ-032 Readout throughput: one sample per cycle when rd_ready is held at 1.
REQ-033 abort=1 in any state: next state is IDLE, rd_valid=0, and no done pulse.
REQ-034 On abort, statistics keep their last values; the stored samples are discarded.
REQ-035 If abort and arm occur in the same cycle, abort wins.
REQ-036 Trigger detection is not active during CAPTURE or READOUT.

Reset
REQ-037 reset=1 takes priority over all inputs.
REQ-038 Reset state: FSM=IDLE, prev_sample=0, all indices=0, rd_valid=0, rd_last=0, busy=0, done=0, min_val=0, max_val=0, zc_count=0, rd_data=0.
REQ-039 reset asserted mid-capture or mid-readout aborts the operation identically to reset from idle.
REQ-040 Sample memory contents are not reset.

Verification (N_SAMPLES=8, WIDTH=8)
REQ-041 Basic capture: arm, then feed -3,-1,2,5,-4,-2,1,7,3,0 with in_valid=1 and rd_ready=1. Required: capture starts at 2; readout is 2,5,-4,-2,1,7,3,0 in 8 consecutive cycles; rd_last on 0; done pulse on the next cycle; min=-4, max=7, zc_count=1.
REQ-042 Backpressure: same stimulus as REQ-041 with rd_ready toggling 1,0,0,1,... Required: rd_data holds through the rd_ready=0 cycles; all 8 samples delivered in order, none duplicated.
REQ-043 Gapped input: in_valid=0 on every other cycle during CAPTURE. Required: stored sequence is identical to REQ-041; no samples are stored from the invalid cycles.
REQ-044 No trigger: arm, then feed a constant 5. Required: FSM stays in WAIT_TRIG, busy=1, rd_valid never asserts; abort then returns busy=0 with no done pulse.
REQ-045 Ignored arm and abort/reset: arm pulse during READOUT has no effect; reset asserted at capture index 4 gives all outputs at reset values on the next cycle, and a new arm starts a fresh acquisition.
